delay_ctrl: RTL

Programmable delay-line controller for the delay datapath. It owns a DEPTH-stage chain of D flip-flops and accepts a delay setting over a valid/ready configuration handshake. On each new setting it clears and refills the chain. It flags when the output is a valid delayed copy of the input, so downstream logic never samples stale or partially-filled line contents.

---
 rtl/delay_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/delay_ctrl.sv
// delay_ctrl: programmable delay-line controller.
//
// Owns a DEPTH-stage flip-flop chain fed by d_in. A delay setting is taken
// over a valid/ready handshake; each accepted setting clears the chain and
// restarts the fill, and q_valid is raised only once the tap holds a sample
// that entered the line after the accept.
//
// Handshake: a setting transfers on a rising clk edge where cfg_valid and
// cfg_ready are both 1. cfg_ready is low only while the line is filling;
// cfg_valid may be held across FILL and is taken on the first ready edge.
//
// Optional feature macro: DELAY_CTRL_BYPASS_EN
//   defined   : cfg_delay=0 is legal, selects bypass (q_out = d_in), RUN at once
//   undefined : cfg_delay=0 is clamped to 1 and flags err
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   cfg_valid  delay setting offered
//   cfg_delay  requested delay in cycles
//   cfg_ready  controller can accept a setting
//   d_in       data into stage 0
//   q_out      tapped output stage[delay-1]
//   q_valid    q_out is d_in from exactly delay cycles earlier
//   busy       line is filling after a new setting
//   err        last accepted setting was illegal and clamped
//   dbg_state  current FSM state (0 UNCFG, 1 FILL, 2 RUN)
module delay_ctrl #(
  parameter int DEPTH = 16,
  parameter int DLW   = 5,
  parameter int DW    = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_valid,
  input  logic [DLW-1:0] cfg_delay,
  output logic           cfg_ready,
  input  logic [DW-1:0]  d_in,
  output logic [DW-1:0]  q_out,
  output logic           q_valid,
  output logic           busy,
  output logic           err,
  output logic [1:0]     dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] S_UNCFG = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]     r_state;
  logic [CW-1:0]  r_fill_cnt;
  logic [DLW-1:0] r_delay;
  logic           r_err;
  logic [DW-1:0]  r_stage [DEPTH];

  logic           w_accept;
  logic [DLW-1:0] w_delay_legal;
  logic           w_err_legal;
  logic [DW-1:0]  w_tap;

  assign cfg_ready = (r_state != S_FILL);
  assign busy      = (r_state == S_FILL);
  assign q_valid   = (r_state == S_RUN);
  assign err       = r_err;
  assign dbg_state = r_state;
  assign w_accept  = cfg_valid && cfg_ready;

  // Legalise the requested delay.
  always_comb begin
    w_delay_legal = cfg_delay;
    w_err_legal   = 1'b0;
    if (cfg_delay > DLW'(DEPTH)) begin
      w_delay_legal = DLW'(DEPTH);
      w_err_legal   = 1'b1;
    end else if (cfg_delay == '0) begin
`ifdef DELAY_CTRL_BYPASS_EN
      w_delay_legal = '0;
      w_err_legal   = 1'b0;
`else
      w_delay_legal = DLW'(1);
      w_err_legal   = 1'b1;
`endif
    end
  end

  // Control FSM. The fill counter holds its final value in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_UNCFG;
      r_fill_cnt <= '0;
      r_delay    <= '0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_delay    <= w_delay_legal;
      r_err      <= w_err_legal;
      r_fill_cnt <= '0;
      // A zero legal delay only exists in bypass builds: no fill needed.
      r_state    <= (w_delay_legal == '0) ? S_RUN : S_FILL;
    end else begin
      case (r_state)
        S_FILL: begin
          r_fill_cnt <= r_fill_cnt + CW'(1);
          if (r_fill_cnt == CW'(r_delay) - CW'(1)) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_fill_cnt <= r_fill_cnt;
        end
      endcase
    end
  end

  // Delay chain; clearing on accept wins over shifting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= d_in;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  // Tap select. r_delay is 0 in UNCFG, which selects no stage and gives 0.
  always_comb begin
    w_tap = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_delay == DLW'(i + 1)) w_tap = r_stage[i];
    end
  end

`ifdef DELAY_CTRL_BYPASS_EN
  assign q_out = ((r_state == S_RUN) && (r_delay == '0)) ? d_in : w_tap;
`else
  assign q_out = w_tap;
`endif

endmodule
